// File: rtl/stream_demux_n.sv
// Packet-aware 1:N stream demultiplexer with one output register per channel.
// Define STREAM_DEMUX_N_DROP_EN to discard packets whose select is out of range.
module stream_demux_n #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [SEL_WIDTH-1:0]         select_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  input  logic                         last_i,
  output logic                         ready_o,
  output logic [CH_NUM*DATA_WIDTH-1:0] data_o,
  output logic [CH_NUM-1:0]            valid_o,
  output logic [CH_NUM-1:0]            last_o,
  input  logic [CH_NUM-1:0]            ready_i,
  output logic                         busy_o
`ifdef STREAM_DEMUX_N_DROP_EN
  ,
  output logic                         drop_o
`endif
);

  typedef enum logic {IDLE, ROUTE} state_e;

  localparam logic [SEL_WIDTH:0]   CH_LIM  = (SEL_WIDTH+1)'(CH_NUM);
  localparam logic [SEL_WIDTH-1:0] CH_LAST = SEL_WIDTH'(CH_NUM-1);

  state_e                      state_q, state_d;
  logic [SEL_WIDTH-1:0]        sel_q, sel_d;
  logic [CH_NUM-1:0]           valid_q, valid_d;
  logic [CH_NUM-1:0]           last_q, last_d;
  logic [CH_NUM*DATA_WIDTH-1:0] data_q, data_d;

  logic [SEL_WIDTH-1:0] cur_sel;
  logic [SEL_WIDTH-1:0] ch_idx;
  logic                 oor;
  logic                 drop;
  logic                 ch_valid;
  logic                 ch_ready;
  logic                 ready;
  logic                 accept;

  // Destination: live select at packet start, latched select afterwards
  always_comb begin
    cur_sel  = (state_q == IDLE) ? select_i : sel_q;
    oor      = {1'b0, cur_sel} >= CH_LIM;
    ch_idx   = oor ? CH_LAST : cur_sel;
`ifdef STREAM_DEMUX_N_DROP_EN
    drop     = oor;
`else
    drop     = 1'b0;
`endif
    ch_valid = 1'b0;
    ch_ready = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_idx == SEL_WIDTH'(k)) begin
        ch_valid = valid_q[k];
        ch_ready = ready_i[k];
      end
    end
    ready  = drop | ~ch_valid | ch_ready;
    accept = valid_i & ready;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = select_i;
          if (!last_i) state_d = ROUTE;
        end
      end
      ROUTE: begin
        if (accept && last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled beat only blocks its own channel
  always_comb begin
    valid_d = valid_q & ~ready_i;
    last_d  = last_q;
    data_d  = data_q;
    for (int k = 0; k < CH_NUM; k++) begin
      if (accept && !drop && ch_idx == SEL_WIDTH'(k)) begin
        valid_d[k] = 1'b1;
        last_d[k]  = last_i;
        data_d[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

`ifdef STREAM_DEMUX_N_DROP_EN
  logic drop_q, drop_d;

  always_comb drop_d = accept & drop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) drop_q <= 1'b0;
    else          drop_q <= drop_d;
  end

  assign drop_o = drop_q;
`endif

  assign ready_o = ready;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q == ROUTE);

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed and scoreboard bench for stream_demux_n (4-channel and 3-channel builds).
module tb_stream_demux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [7:0]  din;
  logic        vin, lin;
  logic [3:0]  rdy;
  logic        ready_o, busy_o;
  logic [31:0] data_o;
  logic [3:0]  valid_o, last_o;

  logic [1:0]  s3;
  logic [7:0]  d3;
  logic        v3, l3;
  logic [2:0]  r3;
  logic        ready3, busy3;
  logic [23:0] data3;
  logic [2:0]  valid3, last3;

`ifdef STREAM_DEMUX_N_DROP_EN
  logic drop_o, drop3;
`endif

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 0;
  int cur_ch = 0;
  logic [8:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_WIDTH(8), .CH_NUM(4), .SEL_WIDTH(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .select_i(sel), .data_i(din),
    .valid_i(vin), .last_i(lin), .ready_o(ready_o), .data_o(data_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(rdy), .busy_o(busy_o)
`ifdef STREAM_DEMUX_N_DROP_EN
    , .drop_o(drop_o)
`endif
  );

  stream_demux_n #(.DATA_WIDTH(8), .CH_NUM(3), .SEL_WIDTH(2)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .select_i(s3), .data_i(d3),
    .valid_i(v3), .last_i(l3), .ready_o(ready3), .data_o(data3),
    .valid_o(valid3), .last_o(last3), .ready_i(r3), .busy_o(busy3)
`ifdef STREAM_DEMUX_N_DROP_EN
    , .drop_o(drop3)
`endif
  );

  function automatic logic [7:0] chd(input int k);
    return data_o[k*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(output bit acc);
    logic [8:0] e;
    @(negedge clk);
    acc = vin && ready_o;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        if (valid_o[k] && rdy[k]) begin
          chk("sb_nonempty", 32'(exp_q[k].size() != 0), 1);
          if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            chk($sformatf("sb_ch%0d", k), {23'b0, last_o[k], chd(k)},
                {23'b0, e});
          end
        end
      end
      if (acc) exp_q[cur_ch].push_back({lin, din});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int len, w;
    rst_n = 0; sel = 0; din = 0; vin = 0; lin = 0; rdy = 4'hF;
    s3 = 0; d3 = 0; v3 = 0; l3 = 0; r3 = 3'b111;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("rel_ready", ready_o, 1);
    chk("rel_busy", busy_o, 0);
    @(posedge clk); #1;

    // single beat to channel 2
    sel = 2; din = 8'hA5; lin = 1; vin = 1;
    cyc(acc);
    vin = 0; lin = 0;
    chk("sb_valid", valid_o, 4'b0100);
    chk("sb_data", chd(2), 8'hA5);
    chk("sb_last", last_o, 4'b0100);
    chk("sb_busy", busy_o, 0);
`ifdef STREAM_DEMUX_N_DROP_EN
    chk("sb_nodrop", drop_o, 0);
`endif
    cyc(acc);

    // back-pressure on channel 1, select toggled mid-packet
    sel = 1; din = 8'h10; vin = 1;
    cyc(acc);
    chk("bp_busy", busy_o, 1);
    chk("bp_b0", chd(1), 8'h10);
    sel = 3; din = 8'h11;
    #1 chk("bp_rdy1", ready_o, 1);
    cyc(acc);
    chk("bp_b1", chd(1), 8'h11);
    chk("bp_v1", valid_o, 4'b0010);
    rdy = 4'b1101; din = 8'h12;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall_rdy", ready_o, 0);
      cyc(acc);
      chk("bp_hold", chd(1), 8'h11);
      chk("bp_hold_v", valid_o, 4'b0010);
    end
    rdy = 4'hF;
    #1 chk("bp_resume", ready_o, 1);
    cyc(acc);
    chk("bp_b2", chd(1), 8'h12);
    din = 8'h13; lin = 1;
    cyc(acc);
    chk("bp_b3", chd(1), 8'h13);
    chk("bp_last", last_o[1], 1);
    chk("bp_v3", valid_o, 4'b0010);
    chk("bp_idle", busy_o, 0);
    vin = 0; lin = 0;
    cyc(acc);
    chk("bp_drain", valid_o, 0);

    // stalled channel 0 must not block channel 3
    rdy = 4'b1110; sel = 0; din = 8'h20; lin = 1; vin = 1;
    cyc(acc);
    chk("il_v0", valid_o, 4'b0001);
    chk("il_d0", chd(0), 8'h20);
    din = 8'h33;
    #1 chk("il_rdy_lo", ready_o, 0);
    sel = 3;
    #1 chk("il_rdy_hi", ready_o, 1);
    cyc(acc);
    chk("il_v03", valid_o, 4'b1001);
    chk("il_d3", chd(3), 8'h33);
    chk("il_hold0", chd(0), 8'h20);
    vin = 0; lin = 0;
    cyc(acc);
    chk("il_v0only", valid_o, 4'b0001);
    chk("il_hold0b", chd(0), 8'h20);
    rdy = 4'hF;
    cyc(acc);
    chk("il_drain", valid_o, 0);

    // asynchronous reset mid-packet
    rdy = 4'h0; sel = 1; din = 8'h44; vin = 1;
    cyc(acc);
    chk("ar_busy", busy_o, 1);
    chk("ar_v", valid_o, 4'b0010);
    vin = 0;
    #2 rst_n = 0;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_data", data_o, 0);
    chk("ar_last", last_o, 0);
    chk("ar_busy0", busy_o, 0);
    #1 rst_n = 1;
    #1;
    chk("ar_ready", ready_o, 1);
    chk("ar_busy1", busy_o, 0);
    @(posedge clk); #1;
    sel = 2; din = 8'h55; lin = 1; vin = 1; rdy = 4'hF;
    cyc(acc);
    chk("ar_start_v", valid_o, 4'b0100);
    chk("ar_start_d", chd(2), 8'h55);
    chk("ar_start_busy", busy_o, 0);
    vin = 0; lin = 0;
    cyc(acc);

    // out-of-range select on the 3-channel build
    s3 = 3; d3 = 8'h61; l3 = 0; v3 = 1;
    #1 chk("oor_rdy0", ready3, 1);
    cyc(acc);
`ifdef STREAM_DEMUX_N_DROP_EN
    chk("oor_drop0", drop3, 1);
    chk("oor_nov0", valid3, 0);
`else
    chk("oor_v0", valid3, 3'b100);
    chk("oor_d0", data3[23:16], 8'h61);
`endif
    s3 = 0; d3 = 8'h62; l3 = 1;
    #1 chk("oor_rdy1", ready3, 1);
    cyc(acc);
`ifdef STREAM_DEMUX_N_DROP_EN
    chk("oor_drop1", drop3, 1);
    chk("oor_nov1", valid3, 0);
`else
    chk("oor_v1", valid3, 3'b100);
    chk("oor_d1", data3[23:16], 8'h62);
    chk("oor_last", last3, 3'b100);
`endif
    v3 = 0; l3 = 0;
    cyc(acc);
    chk("oor_idle", busy3, 0);
    chk("oor_drain", valid3, 0);
`ifdef STREAM_DEMUX_N_DROP_EN
    chk("oor_drop_end", drop3, 0);
`endif

    // random back-to-back packets against a per-channel scoreboard
    mon_en = 1;
    for (int p = 0; p < 256; p++) begin
      cur_ch = $urandom_range(0, 3);
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        sel = (b == 0) ? 2'(cur_ch) : 2'($urandom);
        din = 8'($urandom);
        lin = (b == len - 1);
        vin = 1;
        w = 0;
        do begin
          rdy = 4'($urandom);
          cyc(acc);
          w++;
        end while (!acc && w < 64);
        chk("stream_accept", acc, 1);
      end
    end
    vin = 0; lin = 0; rdy = 4'hF;
    for (int i = 0; i < 4; i++) cyc(acc);
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_left%0d", k), exp_q[k].size(), 0);
    chk("stream_idle", valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
